// File: rtl/farm_pkg.sv
// Shared types and default constants for the irrigation controller.
package farm_pkg;

  typedef enum logic [1:0] {
    IRR_IDLE  = 2'd0,
    IRR_WATER = 2'd1,
    IRR_SOAK  = 2'd2
  } irr_state_t;

  localparam int unsigned DEF_LOW_THR   = 80;
  localparam int unsigned DEF_HIGH_THR  = 180;
  localparam int unsigned DEF_PUMP_TIME = 1000;
  localparam int unsigned DEF_SOAK_TIME = 250;

endpackage

// File: rtl/sensor_window.sv
// One channel's moving-average window: ring buffer, wrapping write pointer, running sum.
module sensor_window
  import farm_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W+WIN_LOG2-1:0] sum
);

  localparam int DEPTH = 1 << WIN_LOG2;

  logic [DATA_W-1:0]   ring [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;

  // The sum always equals the total of the ring entries, so it cannot leave its range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (wr_en) begin
      ring[wr_ptr] <= din;
      wr_ptr       <= wr_ptr + WIN_LOG2'(1);
      sum          <= sum - {{WIN_LOG2{1'b0}}, ring[wr_ptr]} + {{WIN_LOG2{1'b0}}, din};
    end
  end

endmodule

// File: rtl/multi_sensor_irrigation_ctrl.sv
// Multi-channel soil sensor averaging, threshold alerts, and channel-0 driven irrigation FSM.
// Define FARM_HYSTERESIS_EN to let a wet reading (avg0 > HIGH_THR in auto mode) end watering early.
//   state | meaning
//   IDLE  | waiting for manual request or dry reading
//   WATER | pump and valve on, pump timer running
//   SOAK  | post-watering lockout, soak timer running
module multi_sensor_irrigation_ctrl
  import farm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int WIN_LOG2  = 2,
  parameter int TIMER_W   = 12,
  parameter int PUMP_TIME = DEF_PUMP_TIME,
  parameter int SOAK_TIME = DEF_SOAK_TIME,
  parameter int LOW_THR   = DEF_LOW_THR,
  parameter int HIGH_THR  = DEF_HIGH_THR,
  localparam int CH_W     = $clog2(NUM_CH),
  localparam int CNT_W    = $clog2(NUM_CH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CH_W-1:0]          s_ch,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DATA_W-1:0]        cfg_thr,
  input  logic                     auto_mode,
  input  logic                     manual_pump,
  output logic [NUM_CH*DATA_W-1:0] avg_out,
  output logic [NUM_CH-1:0]        alert_vec,
  output logic [CNT_W-1:0]         alert_count,
  output logic                     pump_on,
  output logic                     valve_open,
  output logic [1:0]               irr_state
);

  localparam logic [DATA_W-1:0] THR_RST = {1'b1, {(DATA_W-1){1'b0}}};

  logic                       accept;
  logic [DATA_W+WIN_LOG2-1:0] sum [NUM_CH];
  logic [DATA_W-1:0]          avg [NUM_CH];
  logic [DATA_W-1:0]          thr [NUM_CH];

  assign s_ready = en;
  assign accept  = s_valid & en;

  // Out-of-range channel indices match no window and are silently dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = accept && (s_ch == CH_W'(i));

    sensor_window #(
      .DATA_W  (DATA_W),
      .WIN_LOG2(WIN_LOG2)
    ) u_win (
      .clk  (clk),
      .rst  (rst),
      .wr_en(wr_en),
      .din  (s_data),
      .sum  (sum[i])
    );

    assign avg[i] = sum[i][DATA_W+WIN_LOG2-1:WIN_LOG2];
    assign avg_out[i*DATA_W +: DATA_W] = avg[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) thr[i] <= THR_RST;
      alert_vec <= '0;
    end else if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) thr[i] <= cfg_thr;
        alert_vec[i] <= (avg[i] > thr[i]);
      end
    end
  end

  always_comb begin
    alert_count = '0;
    for (int i = 0; i < NUM_CH; i++) alert_count = alert_count + CNT_W'(alert_vec[i]);
  end

  irr_state_t         state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               start_req;
  logic               wet_exit;

  assign start_req = manual_pump || (auto_mode && (avg[0] < DATA_W'(LOW_THR)));

`ifdef FARM_HYSTERESIS_EN
  assign wet_exit = auto_mode && (avg[0] > DATA_W'(HIGH_THR));
`else
  assign wet_exit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IRR_IDLE: begin
        if (start_req) begin
          state_nxt = IRR_WATER;
          timer_nxt = TIMER_W'(PUMP_TIME - 1);
        end
      end
      IRR_WATER: begin
        if ((timer == '0) || wet_exit) begin
          state_nxt = IRR_SOAK;
          timer_nxt = TIMER_W'(SOAK_TIME - 1);
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      IRR_SOAK: begin
        if (timer == '0) state_nxt = IRR_IDLE;
        else             timer_nxt = timer - TIMER_W'(1);
      end
      default: begin
        state_nxt = IRR_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Drives are registered from the next state so they line up exactly with WATER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IRR_IDLE;
      timer      <= '0;
      pump_on    <= 1'b0;
      valve_open <= 1'b0;
    end else if (en) begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      pump_on    <= (state_nxt == IRR_WATER);
      valve_open <= (state_nxt == IRR_WATER);
    end
  end

  assign irr_state = state;

endmodule

// File: tb/tb_multi_sensor_irrigation_ctrl.sv
// Directed self-checking bench for multi_sensor_irrigation_ctrl (default parameters plus a 6-channel instance).
module tb_multi_sensor_irrigation_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_ch = '0;
  logic [7:0]  s_data = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [7:0]  cfg_thr = '0;
  logic        auto_mode = 1'b0;
  logic        manual_pump = 1'b0;
  logic [31:0] avg_out;
  logic [3:0]  alert_vec;
  logic [2:0]  alert_count;
  logic        pump_on, valve_open;
  logic [1:0]  irr_state;

  logic        s_valid6 = 1'b0;
  logic        s_ready6;
  logic [2:0]  s_ch6 = '0;
  logic [7:0]  s_data6 = '0;
  logic [47:0] avg_out6;
  logic [5:0]  alert_vec6;
  logic [2:0]  alert_count6;
  logic        pump_on6, valve_open6;
  logic [1:0]  irr_state6;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0, t1, t2;
  int exp_dur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_sensor_irrigation_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_ch(s_ch), .s_data(s_data), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thr(cfg_thr),
    .auto_mode(auto_mode), .manual_pump(manual_pump), .avg_out(avg_out),
    .alert_vec(alert_vec), .alert_count(alert_count), .pump_on(pump_on),
    .valve_open(valve_open), .irr_state(irr_state)
  );

  multi_sensor_irrigation_ctrl #(.NUM_CH(6)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid6), .s_ready(s_ready6),
    .s_ch(s_ch6), .s_data(s_data6), .cfg_we(1'b0), .cfg_ch(3'd0), .cfg_thr(8'd0),
    .auto_mode(1'b0), .manual_pump(1'b0), .avg_out(avg_out6),
    .alert_vec(alert_vec6), .alert_count(alert_count6), .pump_on(pump_on6),
    .valve_open(valve_open6), .irr_state(irr_state6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] d);
    s_valid = 1'b1;
    s_ch    = ch;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_pump_off(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!pump_on) break;
      step();
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (irr_state == 2'd0) break;
      step();
    end
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_avg", avg_out, 0);
    check("rst_alert", alert_vec, 0);
    check("rst_count", alert_count, 0);
    check("rst_pump", pump_on, 0);
    check("rst_valve", valve_open, 0);
    check("rst_state", irr_state, 0);
    check("rst_ready", s_ready, 1);

    // ch1 moving average
    send(2'd1, 8'd40);   check("avg1_a", avg_out[15:8], 10);
    send(2'd1, 8'd80);   check("avg1_b", avg_out[15:8], 30);
    send(2'd1, 8'd120);  check("avg1_c", avg_out[15:8], 60);
    send(2'd1, 8'd160);  check("avg1_d", avg_out[15:8], 100);
    // fifth sample overwrites the oldest while a threshold write lands the same cycle
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_thr = 8'd200;
    send(2'd1, 8'd200);
    cfg_we = 1'b0;
    check("avg1_wrap", avg_out[15:8], 140);

    // ch2 alert
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_thr = 8'd50;
    step();
    cfg_we = 1'b0;
    send(2'd2, 8'd60);
    send(2'd2, 8'd60);
    send(2'd2, 8'd60);
    send(2'd2, 8'd60);
    check("avg2", avg_out[23:16], 60);
    check("alert_lag", alert_vec, 4'b0000);
    step();
    check("alert_vec", alert_vec, 4'b0100);
    check("alert_count", alert_count, 1);
    check("avg_all", avg_out, {8'd0, 8'd60, 8'd140, 8'd0});

    // en low blocks acceptance
    en = 1'b0;
    send(2'd3, 8'd100);
    check("en_ready", s_ready, 0);
    check("en_hold_avg", avg_out, {8'd0, 8'd60, 8'd140, 8'd0});
    en = 1'b1;

    // out-of-range channel on the 6-channel instance
    s_valid6 = 1'b1; s_ch6 = 3'd6; s_data6 = 8'd200;
    step();
    check("ch6_discard", avg_out6, 0);
    s_ch6 = 3'd5;
    step();
    s_valid6 = 1'b0;
    check("ch5_accept", avg_out6, {8'd50, 40'd0});

    // automatic watering from dry channel 0
    auto_mode = 1'b1;
    step();
    t0 = cyc;
    check("auto_state", irr_state, 1);
    check("auto_pump", pump_on, 1);
    check("auto_valve", valve_open, 1);
    send(2'd0, 8'd20);
    send(2'd0, 8'd20);
    send(2'd0, 8'd20);
    send(2'd0, 8'd20);
    check("avg0_dry", avg_out[7:0], 20);
    send(2'd0, 8'd200);
    send(2'd0, 8'd200);
    send(2'd0, 8'd200);
    send(2'd0, 8'd200);
    check("avg0_wet", avg_out[7:0], 200);
    wait_pump_off(2000);
    t1 = cyc;
`ifdef FARM_HYSTERESIS_EN
    exp_dur = 9;
`else
    exp_dur = 1000;
`endif
    check("water_len", t1 - t0, exp_dur);
    check("soak_state", irr_state, 2);
    check("soak_valve", valve_open, 0);
    step();
    step();
    manual_pump = 1'b1;
    step();
    manual_pump = 1'b0;
    check("manual_in_soak", irr_state, 2);
    check("manual_in_soak_pump", pump_on, 0);
    wait_idle(1000);
    t2 = cyc;
    check("soak_len", t2 - t1, 250);
    step();
    check("idle_wet_stays", irr_state, 0);
    auto_mode = 1'b0;

    // manual watering with a 10-cycle freeze
    manual_pump = 1'b1;
    step();
    manual_pump = 1'b0;
    t0 = cyc;
    check("manual_state", irr_state, 1);
    repeat (5) step();
    en = 1'b0;
    repeat (10) step();
    check("freeze_state", irr_state, 1);
    check("freeze_pump", pump_on, 1);
    en = 1'b1;
    wait_pump_off(3000);
    t1 = cyc;
    check("freeze_len", t1 - t0, 1010);
    wait_idle(1000);
    check("back_idle", irr_state, 0);

    // asynchronous reset mid-WATER
    manual_pump = 1'b1;
    step();
    manual_pump = 1'b0;
    check("rst_test_water", pump_on, 1);
    repeat (3) step();
    rst = 1'b1;
    #2;
    check("async_pump", pump_on, 0);
    check("async_valve", valve_open, 0);
    check("async_state", irr_state, 0);
    step();
    rst = 1'b0;
    check("post_rst_avg", avg_out, 0);
    check("post_rst_alert", alert_vec, 0);
    step();
    check("post_rst_idle", irr_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_sensor_irrigation_ctrl.md
MULTI_SENSOR_IRRIGATION_CTRL -- requirements
Module: multi_sensor_irrigation_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_CH, 4, sensor channels, legal range 2..8.
- DATA_W, 8, sample width.
- WIN_LOG2, 2, log2 of averaging window depth, legal range 1..4.
- TIMER_W, 12, timer width.
- PUMP_TIME, 1000, watering duration in cycles.
- SOAK_TIME, 250, post-watering lockout in cycles.
- LOW_THR, 80, start-watering level.
- HIGH_THR, 180, stop-watering level.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- en, in, 1, global enable; when low, all state freezes.
- s_valid, in, 1, sample valid.
- s_ready, out, 1, sample ready; equals en.
- s_ch, in, clog2(NUM_CH), channel index.
- s_data, in, DATA_W, sample value.
- cfg_we, in, 1, threshold write strobe.
- cfg_ch, in, clog2(NUM_CH), channel to write.
- cfg_thr, in, DATA_W, threshold value.
- auto_mode, in, 1, enables automatic watering.
- manual_pump, in, 1, single-cycle manual watering request.
- avg_out, out, NUM_CH*DATA_W, per-channel averages; channel i at bits [i*DATA_W +: DATA_W].
- alert_vec, out, NUM_CH, per-channel alert flags.
- alert_count, out, clog2(NUM_CH+1), popcount of alert_vec.
- pump_on, out, 1, pump drive.
- valve_open, out, 1, valve drive.
- irr_state, out, 2, FSM state: IDLE=0, WATER=1, SOAK=2.

Function
REQ-003 A sample SHALL be accepted on any clk edge where s_valid and s_ready are both high; samples with s_ch >= NUM_CH SHALL be accepted and discarded.
REQ-004 Each channel SHALL keep a ring buffer of 2^WIN_LOG2 samples, a write pointer that wraps modulo the depth, and a running sum of width DATA_W+WIN_LOG2.
REQ-005 On acceptance, the addressed channel's sum SHALL update to sum - oldest + s_data, overwriting the oldest entry; the update SHALL never overflow or underflow.
REQ-006 avg_out for a channel SHALL equal sum >> WIN_LOG2 and SHALL reflect an accepted sample on the cycle after acceptance (latency 1).
REQ-007 Per-channel thresholds SHALL be written on cfg_we; a write and a sample in the same cycle SHALL both take effect.
REQ-008 alert_vec[i] SHALL be registered as avg[i] > thr[i], lagging avg_out by 1 cycle; alert_count SHALL be the combinational popcount of alert_vec.
REQ-009 Channel 0 SHALL drive the irrigation FSM:
- IDLE -> WATER when manual_pump is high, or when auto_mode is high and avg0 < LOW_THR; timer loads PUMP_TIME-1.
- WATER -> SOAK when the timer reaches 0; timer loads SOAK_TIME-1.
- SOAK -> IDLE when the timer reaches 0.
REQ-010 pump_on and valve_open SHALL both be registered and high exactly while irr_state is WATER.
REQ-011 manual_pump SHALL be ignored in WATER and SOAK; auto_mode falling during WATER SHALL NOT end watering early.
REQ-012 When en is low, no sample SHALL be accepted, buffers, thresholds, FSM and timer SHALL hold, and outputs SHALL hold their values.

Reset
REQ-013 When rst is asserted, the block SHALL immediately reset: buffers, pointers and sums to 0, thresholds to 2^(DATA_W-1), alert_vec to 0, state to IDLE, timer to 0, pump_on and valve_open to 0.
REQ-014 A reset asserted during WATER SHALL drop pump_on and valve_open asynchronously; after release the FSM SHALL start in IDLE.

Configuration
REQ-015 With FARM_HYSTERESIS_EN defined, WATER SHALL also exit to SOAK on the cycle after avg0 > HIGH_THR is observed while auto_mode is high; without the macro, WATER SHALL end only on timer expiry.

Structure
REQ-016 Package farm_pkg SHALL hold the irr_state enum and the default LOW_THR, HIGH_THR, PUMP_TIME and SOAK_TIME constants.
REQ-017 Sub-module sensor_window, holding one channel's ring buffer, pointer and sum, SHALL be instantiated NUM_CH times.

Verification
REQ-018 The bench SHALL cover these directed scenarios with default parameters:
- Samples 40, 80, 120, 160 on ch1 -> avg1 sequence 10, 30, 60, 100; a fifth sample 200 -> avg1 = 140.
- cfg_thr ch2 = 50, then four samples of 60 on ch2 -> alert_vec[2] = 1 and alert_count = 1.
- auto_mode = 1, four samples of 20 on ch0 -> WATER; pump_on high for exactly 1000 cycles, then SOAK for 250 cycles, then IDLE.
- FARM_HYSTERESIS_EN defined, in WATER, four samples of 200 on ch0 -> SOAK well before 1000 cycles; without the macro -> full 1000 cycles.
- rst pulse mid-WATER -> pump_on = 0 before the next clk edge; en = 0 for 10 cycles mid-WATER -> timer expiry delayed by exactly 10 cycles.
- s_ch = 6 -> no avg_out change; manual_pump during SOAK -> ignored.
